// File: rtl/rtc_bus_sequencer.sv
// Multiplexed address/data bus sequencer for an external RTC chip.
// A request becomes one 28-slot cycle; every strobe is decoded from the slot count.
module rtc_bus_sequencer #(
  parameter logic [4:0] SLOT_LAST = 5'd27,
  parameter logic [4:0] RD_SAMPLE = 5'd23
) (
  input  logic       clk,
  input  logic       reset_clk,
  input  logic [4:0] conta,
  output logic       cnt_rst,
  input  logic       req,
  input  logic       wr_nrd,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic [7:0] bus_in
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, bus_out_q, bus_out_d;
  logic       wr_nrd_q, wr_nrd_d;
  logic       cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic       ad_q, ad_d, bus_oe_q, bus_oe_d, done_q, done_d;

  function automatic logic in_rng(input logic [4:0] v, input logic [4:0] lo, input logic [4:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset_clk) begin
    if (!reset_clk) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; slot counts beyond SLOT_LAST also end the transaction
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = RUN; else state_d = IDLE;
      RUN:     if (conta >= SLOT_LAST) state_d = DONE; else state_d = RUN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobe decode for the next cycle; anything outside RUN decodes to the idle bus
  always_comb begin
    cs_n_d    = 1'b1;
    rd_n_d    = 1'b1;
    wr_n_d    = 1'b1;
    ad_d      = 1'b1;
    bus_oe_d  = 1'b0;
    bus_out_d = 8'h00;
    done_d    = 1'b0;
    if (state_q == RUN) begin
      done_d = (conta >= SLOT_LAST);
      if (conta > SLOT_LAST) begin
        ad_d = 1'b1;
      end else if (conta <= 5'd13) begin
        ad_d      = 1'b0;
        bus_oe_d  = in_rng(conta, 5'd1, 5'd12);
        bus_out_d = bus_oe_d ? addr_q : 8'h00;
        cs_n_d    = !in_rng(conta, 5'd2, 5'd11);
        wr_n_d    = !in_rng(conta, 5'd4, 5'd9);
      end else begin
        cs_n_d = !in_rng(conta, 5'd16, 5'd25);
        if (wr_nrd_q) begin
          bus_oe_d  = in_rng(conta, 5'd15, 5'd26);
          bus_out_d = bus_oe_d ? wdata_q : 8'h00;
          wr_n_d    = !in_rng(conta, 5'd18, 5'd23);
        end else begin
          rd_n_d = !in_rng(conta, 5'd18, 5'd23);
        end
      end
    end else begin
      done_d = 1'b0;
    end
  end

  // Request latch and read capture
  always_comb begin
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_nrd_d = wr_nrd_q;
    rdata_d  = rdata_q;
    if ((state_q == IDLE) && req) begin
      addr_d   = addr;
      wdata_d  = wdata;
      wr_nrd_d = wr_nrd;
    end else begin
      wr_nrd_d = wr_nrd_q;
    end
    if ((state_q == RUN) && !wr_nrd_q && (conta == RD_SAMPLE)) begin
      rdata_d = bus_in;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Registered strobes, completion pulse and data
  always_ff @(posedge clk or negedge reset_clk) begin
    if (!reset_clk) begin
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      wr_nrd_q  <= 1'b0;
      rdata_q   <= 8'h00;
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      ad_q      <= 1'b1;
      bus_oe_q  <= 1'b0;
      bus_out_q <= 8'h00;
      done_q    <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_nrd_q  <= wr_nrd_d;
      rdata_q   <= rdata_d;
      cs_n_q    <= cs_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      ad_q      <= ad_d;
      bus_oe_q  <= bus_oe_d;
      bus_out_q <= bus_out_d;
      done_q    <= done_d;
    end
  end

  assign cnt_rst = (state_q != RUN);
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign cs_n    = cs_n_q;
  assign rd_n    = rd_n_q;
  assign wr_n    = wr_n_q;
  assign ad      = ad_q;
  assign bus_oe  = bus_oe_q;
  assign bus_out = bus_out_q;

endmodule
